// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op and state encodings for the iterative multiply/divide unit
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    CALC = 2'b10,
    FIX  = 2'b11
  } state_t;

endpackage

// File: rtl/muldiv_div_step.sv
// rtl/muldiv_div_step.sv - one combinational restoring-division iteration on {rem, quot}
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quot
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;

  // The shifted remainder needs WIDTH+1 bits when the divisor uses the full width.
  assign w_shift = {i_rem, i_quot[WIDTH-1]};
  assign w_fits  = (w_shift >= {1'b0, i_divisor});
  assign w_diff  = w_shift[WIDTH-1:0] - i_divisor;

  assign o_rem  = w_fits ? w_diff : w_shift[WIDTH-1:0];
  assign o_quot = {i_quot[WIDTH-2:0], w_fits};

endmodule

// File: rtl/iter_muldiv_unit.sv
// rtl/iter_muldiv_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Optional MULDIV_EARLY_TERM_EN: multiply leaves CALC once the remaining multiplier bits are zero.
module iter_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  state_t           r_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_opnd;
  logic [2*WIDTH:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_psign;
  logic             r_rsign;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic               w_is_div;
  logic               w_is_signed;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_upper_sum;
  logic [2*WIDTH:0]   w_mul_next;
  logic [WIDTH-1:0]   w_rem_n;
  logic [WIDTH-1:0]   w_quot_n;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic               w_mul_exit;

  assign w_is_div    = r_op[1];
  assign w_is_signed = ~r_op[0];

  // Negating the most-negative value leaves its bit pattern, which reads as 2^(WIDTH-1) unsigned.
  assign w_a_mag = (w_is_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_b_mag = (w_is_signed && r_b[WIDTH-1]) ? -r_b : r_b;

  // Multiply: r_acc = {carry, upper partial product, remaining multiplier bits}.
  assign w_addend    = r_acc[0] ? r_opnd : {WIDTH{1'b0}};
  assign w_upper_sum = r_acc[2*WIDTH:WIDTH] + {1'b0, w_addend};
  assign w_mul_next  = {1'b0, w_upper_sum, r_acc[WIDTH-1:1]};

  muldiv_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .i_rem    (r_acc[2*WIDTH-1:WIDTH]),
    .i_quot   (r_acc[WIDTH-1:0]),
    .i_divisor(r_opnd),
    .o_rem    (w_rem_n),
    .o_quot   (w_quot_n)
  );

`ifdef MULDIV_EARLY_TERM_EN
  logic [WIDTH-1:0] w_left_mask;

  // Bits 1..r_cnt-1 of the low half are the multiplier bits still unshifted after this iteration.
  always_comb begin
    w_left_mask = {WIDTH{1'b0}};
    for (int i = 1; i < WIDTH; i++) begin
      w_left_mask[i] = (CNT_W'(i) < r_cnt);
    end
  end

  assign w_mul_exit = !w_is_div && ((r_acc[WIDTH-1:0] & w_left_mask) == {WIDTH{1'b0}});
  assign w_prod     = r_acc[2*WIDTH-1:0] >> r_cnt;
`else
  assign w_mul_exit = 1'b0;
  assign w_prod     = r_acc[2*WIDTH-1:0];
`endif

  assign w_prod_fix = r_psign ? -w_prod : w_prod;
  assign w_quot_fix = r_psign ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_rsign ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_op    <= MULT;
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_opnd  <= {WIDTH{1'b0}};
      r_acc   <= {(2*WIDTH+1){1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_psign <= 1'b0;
      r_rsign <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= {WIDTH{1'b0}};
      r_lo    <= {WIDTH{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op    <= op_t'(op);
            r_a     <= a;
            r_b     <= b;
            r_busy  <= 1'b1;
            r_dbz   <= 1'b0;
            r_state <= PREP;
          end
        end
        PREP: begin
          r_psign <= w_is_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_rsign <= w_is_signed & r_a[WIDTH-1];
          r_opnd  <= w_is_div ? w_b_mag : w_a_mag;
          r_acc   <= {{(WIDTH+1){1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
          r_cnt   <= CNT_W'(WIDTH);
          if (w_is_div && (r_b == {WIDTH{1'b0}})) begin
            r_dbz   <= 1'b1;
            r_state <= FIX;
          end else begin
            r_state <= CALC;
          end
        end
        CALC: begin
          r_acc <= w_is_div ? {1'b0, w_rem_n, w_quot_n} : w_mul_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if ((r_cnt == CNT_W'(1)) || w_mul_exit) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          if (r_dbz) begin
            r_hi <= r_a;
            r_lo <= {WIDTH{1'b1}};
          end else if (w_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quot_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// tb/tb_iter_muldiv_unit.sv - self-checking bench for iter_muldiv_unit against an arithmetic model
module tb_iter_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int total = 0;
  int bad = 0;
  int n_done = 0;

  iter_muldiv_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Results straight from integer arithmetic; latency from the cycle budget of each op.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] eh, output logic [W-1:0] el,
                                output bit ez, output int lat);
    longint sx, sy, q, r;
    logic [63:0] p;
    logic [W-1:0] mag;
    int k;
    sx = $signed(x);
    sy = $signed(y);
    ez = 0;
    lat = W + 2;
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = {32'b0, x} * {32'b0, y}; eh = p[63:32]; el = p[31:0]; end
      2'b10: begin
        if (y == 0) begin ez = 1; eh = x; el = '1; lat = 2; end
        else begin q = sx / sy; r = sx % sy; eh = r[31:0]; el = q[31:0]; end
      end
      default: begin
        if (y == 0) begin ez = 1; eh = x; el = '1; lat = 2; end
        else begin
          p = {32'b0, x} / {32'b0, y}; el = p[31:0];
          p = {32'b0, x} % {32'b0, y}; eh = p[31:0];
        end
      end
    endcase
`ifdef MULDIV_EARLY_TERM_EN
    if (!o[1]) begin
      mag = (!o[0] && y[W-1]) ? -y : y;
      k = 1;
      for (int i = 0; i < W; i++) if (mag[i]) k = i + 1;
      lat = 2 + k;
    end
`endif
  endfunction

  function automatic int lit_lat(input int dflt, input int early);
`ifdef MULDIV_EARLY_TERM_EN
    return early;
`else
    return dflt;
`endif
  endfunction

  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  bit m_busy, m_done, m_dbz, p_dbz;
  int m_left, p_lat;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_busy = 0; m_done = 0; m_dbz = 0; m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (p_dbz && m_left == p_lat - 1) m_dbz = 1;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_hi = p_hi; m_lo = p_lo;
        end
      end else if (start) begin
        model(op, a, b, p_hi, p_lo, p_dbz, p_lat);
        m_busy = 1; m_left = p_lat; m_dbz = 0;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
      chk("cyc_done", {31'b0, done}, {31'b0, m_done});
      chk("cyc_dbz", {31'b0, div_by_zero}, {31'b0, m_dbz});
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
      if (done) n_done++;
    end
  end

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op; optionally pulse a conflicting start inj cycles after the accept edge.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int inj, input int exp_lat, input logic [W-1:0] eh,
                        input logic [W-1:0] el, input bit ez, input string nm);
    int n, nbusy;
    @(negedge CLK);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge CLK);
    #1 start = 1'b0;
    n = 0;
    nbusy = busy ? 1 : 0;
    while (!done && n < 200) begin
      if (n == inj) begin start = 1'b1; op = DIVU; a = 32'd77; b = 32'd5; end
      else start = 1'b0;
      @(posedge CLK);
      #1 n++;
      if (busy) nbusy++;
    end
    start = 1'b0;
    chk({nm, "_latency"}, n, exp_lat);
    chk({nm, "_busy_cycles"}, nbusy, exp_lat);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    chk({nm, "_dbz"}, {31'b0, div_by_zero}, {31'b0, ez});
  endtask

  initial begin
    logic [W-1:0] th, tl;
    bit tz;
    int tlat, seen, d0;

    model(MULTU, 32'hFFFF_FFFF, 32'd2, th, tl, tz, tlat);
    chk("pin_multu_hi", th, 32'h1);
    chk("pin_multu_lo", tl, 32'hFFFF_FFFE);
    model(DIV, 32'hFFFF_FFF9, 32'd2, th, tl, tz, tlat);
    chk("pin_div_hi", th, 32'hFFFF_FFFF);
    chk("pin_div_lo", tl, 32'hFFFF_FFFD);
    model(DIV, 32'h8000_0000, 32'hFFFF_FFFF, th, tl, tz, tlat);
    chk("pin_divmin_lo", tl, 32'h8000_0000);
    chk("pin_divmin_hi", th, 32'h0);

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    chk_en = 1;

    run_op(MULTU, 32'hFFFF_FFFF, 32'd2, -1, lit_lat(34, 4), 32'h1, 32'hFFFF_FFFE, 0, "multu_max");
    run_op(MULT, 32'hFFFF_FFFD, 32'd5, -1, lit_lat(34, 5), 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, "mult_neg");
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, -1, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, "div_neg");
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 34, 32'h0, 32'h8000_0000, 0, "div_min");
    run_op(DIVU, 32'h1234, 32'd0, -1, 2, 32'h1234, 32'hFFFF_FFFF, 1, "divu_zero");
    run_op(DIVU, 32'd9, 32'd4, -1, 34, 32'd1, 32'd2, 0, "divu_9_4");
    run_op(MULTU, 32'h10, 32'h8000_0003, 4, 34, 32'h8, 32'h30, 0, "ignore_start");
    run_op(MULTU, 32'd7, 32'd1, -1, lit_lat(34, 3), 32'h0, 32'h7, 0, "multu_7_1");

    run_op(DIVU, 32'd9, 32'd4, -1, 34, 32'd1, 32'd2, 0, "pre_rst");
    @(negedge CLK);
    start = 1'b1; op = MULTU; a = 32'd5; b = 32'h8000_0001;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (10) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    chk("async_rst_done", {31'b0, done}, 32'd0);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge CLK);
      #1 if (done || busy) seen++;
    end
    chk("no_done_after_rst", seen, 0);

    d0 = n_done;
    for (int i = 0; i < 6000; i++) begin
      @(negedge CLK);
      start = ($urandom_range(0, 3) == 0);
      op = 2'($urandom_range(0, 3));
      a = rnd_val();
      b = rnd_val();
    end
    @(negedge CLK);
    start = 1'b0;
    seen = 0;
    while (m_busy && seen < 100) begin
      @(negedge CLK);
      seen++;
    end
    chk("random_drained", {31'b0, m_busy}, 32'd0);
    chk("random_ops_seen", (n_done - d0 >= 50) ? 32'd1 : 32'd0, 32'd1);
    @(negedge CLK);
    chk_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
